// File: rtl/soc_ctrl_pll_lock_seq_if.sv
// Status and control bundle between the SoC controller and the PLL lock sequencer.
// The master drives the raw lock and software requests; the slave returns the delay-gen triplet and status.
interface soc_ctrl_pll_lock_seq_if;
    logic       pll_lock_raw;
    logic       dom_en;
    logic       lock_lost_clr;
    logic       pll_lock;
    logic       dom_arst_n;
    logic       dom_clk_en;
    logic       lock_lost;
    logic       timeout;
    logic [2:0] state;

    modport master (
        output pll_lock_raw, dom_en, lock_lost_clr,
        input  pll_lock, dom_arst_n, dom_clk_en, lock_lost, timeout, state
    );

    modport slave (
        input  pll_lock_raw, dom_en, lock_lost_clr,
        output pll_lock, dom_arst_n, dom_clk_en, lock_lost, timeout, state
    );
endinterface

// File: rtl/soc_ctrl_pll_lock_seq.sv
// PLL lock qualifier and domain clock/reset sequencer; outputs are registered decodes of the next state.
// Raw lock reaches the FSM after SYNC_STAGES edges; no backpressure, inputs are levels/pulses sampled every cycle.
module soc_ctrl_pll_lock_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int GATE_CYCLES         = 4
) (
    input  logic                    ref_clk_i,
    input  logic                    glb_rst_ni,
    soc_ctrl_pll_lock_seq_if.slave  bus
);
    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ACQ   = 3'd1,
        ST_RUN   = 3'd2,
        ST_GATE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [STAB_W-1:0]   stab_q, stab_nxt;
    logic [TO_W-1:0]     to_q, to_nxt;
    logic [GATE_W-1:0]   gate_q, gate_nxt;
    logic                lost_gate_q, lost_gate_nxt;
    logic                lock_lost_q, timeout_q;
    logic                pll_lock_q, arst_n_q, clk_en_q;
    logic                pll_lock_nxt, arst_n_nxt, clk_en_nxt;
    logic                set_lost, set_to, clr_to;
    logic                lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt     = state_q;
        stab_nxt      = stab_q;
        to_nxt        = to_q;
        gate_nxt      = gate_q;
        lost_gate_nxt = lost_gate_q;
        set_lost      = 1'b0;
        set_to        = 1'b0;
        clr_to        = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (bus.dom_en) begin
                    state_nxt = ST_ACQ;
                    stab_nxt  = '0;
                    to_nxt    = '0;
                    clr_to    = 1'b1;
                end
            end
            ST_ACQ: begin
                to_nxt   = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
                stab_nxt = !lock_s ? '0 : (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
                if (!bus.dom_en) begin
                    state_nxt = ST_OFF;
                end else if (lock_s && stab_q == STAB_LAST) begin
                    state_nxt = ST_RUN;
                end else if (to_q == TO_LAST) begin
                    state_nxt = ST_FAULT;
                    set_to    = 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss outranks a disable so the sticky flag and reacquire intent are recorded.
                if (!lock_s) begin
                    state_nxt     = ST_GATE;
                    gate_nxt      = '0;
                    lost_gate_nxt = 1'b1;
                    set_lost      = 1'b1;
                end else if (!bus.dom_en) begin
                    state_nxt     = ST_GATE;
                    gate_nxt      = '0;
                    lost_gate_nxt = 1'b0;
                end
            end
            ST_GATE: begin
                if (gate_q == GATE_LAST) begin
                    if (bus.dom_en && lost_gate_q) begin
                        state_nxt = ST_ACQ;
                        stab_nxt  = '0;
                        to_nxt    = '0;
                    end else begin
                        state_nxt = ST_OFF;
                    end
                end else begin
                    gate_nxt = gate_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (!bus.dom_en) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase

        pll_lock_nxt = 1'b0;
        arst_n_nxt   = 1'b0;
        clk_en_nxt   = 1'b0;
        case (state_nxt)
            ST_RUN:  begin pll_lock_nxt = 1'b1; arst_n_nxt = 1'b1; clk_en_nxt = 1'b1; end
            ST_GATE: begin pll_lock_nxt = 1'b1; arst_n_nxt = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge ref_clk_i) begin
        if (!glb_rst_ni) begin
            state_q     <= ST_OFF;
            sync_q      <= '0;
            stab_q      <= '0;
            to_q        <= '0;
            gate_q      <= '0;
            lost_gate_q <= 1'b0;
            lock_lost_q <= 1'b0;
            timeout_q   <= 1'b0;
            pll_lock_q  <= 1'b0;
            arst_n_q    <= 1'b0;
            clk_en_q    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock_raw};
            stab_q      <= stab_nxt;
            to_q        <= to_nxt;
            gate_q      <= gate_nxt;
            lost_gate_q <= lost_gate_nxt;
            lock_lost_q <= set_lost | (lock_lost_q & ~bus.lock_lost_clr);
            timeout_q   <= set_to | (timeout_q & ~clr_to);
            pll_lock_q  <= pll_lock_nxt;
            arst_n_q    <= arst_n_nxt;
            clk_en_q    <= clk_en_nxt;
        end
    end

    assign bus.pll_lock   = pll_lock_q;
    assign bus.dom_arst_n = arst_n_q;
    assign bus.dom_clk_en = clk_en_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.timeout    = timeout_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_soc_ctrl_pll_lock_seq.sv
// Bench for the PLL lock sequencer: directed scenarios plus random lock/enable traffic against a cycle model.
module tb_soc_ctrl_pll_lock_seq;
    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int TMO    = 4096;
    localparam int GATE   = 4;

    localparam int M_OFF = 0, M_ACQ = 1, M_RUN = 2, M_GATE = 3, M_FAULT = 4;

    logic ref_clk = 1'b0;
    logic glb_rst_n = 1'b0;
    soc_ctrl_pll_lock_seq_if bus ();

    soc_ctrl_pll_lock_seq #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(STABLE),
        .LOCK_TIMEOUT_CYCLES(TMO), .GATE_CYCLES(GATE)
    ) dut (
        .ref_clk_i (ref_clk),
        .glb_rst_ni(glb_rst_n),
        .bus       (bus.slave)
    );

    always #5 ref_clk = ~ref_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the raw-lock delay line plus elapsed-time bookkeeping per phase.
    logic sync_line[$];
    int   m_mode = M_OFF;
    int   m_highs, m_waited, m_gate_left;
    bit   m_reason, m_lost, m_to;

    task automatic model_step(input logic raw, input logic en, input logic clr, input logic rst_n);
        logic ls;
        bit set_l;
        if (!rst_n) begin
            m_mode = M_OFF; m_highs = 0; m_waited = 0; m_gate_left = 0;
            m_reason = 0; m_lost = 0; m_to = 0;
            sync_line.delete();
            for (int i = 0; i < SYNC; i++) sync_line.push_back(1'b0);
            return;
        end
        ls = sync_line.pop_front();
        sync_line.push_back(raw);
        set_l = 0;
        case (m_mode)
            M_OFF: if (en) begin m_mode = M_ACQ; m_highs = 0; m_waited = 0; m_to = 0; end
            M_ACQ: begin
                if (!en) m_mode = M_OFF;
                else if (ls && m_highs + 1 >= STABLE) m_mode = M_RUN;
                else if (m_waited + 1 >= TMO) begin m_mode = M_FAULT; m_to = 1; end
                else begin
                    m_highs  = ls ? m_highs + 1 : 0;
                    m_waited = m_waited + 1;
                end
            end
            M_RUN: begin
                if (!ls) begin m_mode = M_GATE; m_gate_left = GATE; m_reason = 1; set_l = 1; end
                else if (!en) begin m_mode = M_GATE; m_gate_left = GATE; m_reason = 0; end
            end
            M_GATE: begin
                m_gate_left = m_gate_left - 1;
                if (m_gate_left == 0) begin
                    if (en && m_reason) begin m_mode = M_ACQ; m_highs = 0; m_waited = 0; end
                    else m_mode = M_OFF;
                end
            end
            default: if (!en) m_mode = M_OFF;
        endcase
        if (set_l) m_lost = 1;
        else if (clr) m_lost = 0;
    endtask

    function automatic logic [7:0] exp_vec();
        logic [2:0] trip;
        case (m_mode)
            M_RUN:   trip = 3'b111;
            M_GATE:  trip = 3'b110;
            default: trip = 3'b000;
        endcase
        return {3'(m_mode), trip, m_lost, m_to};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.state, bus.pll_lock, bus.dom_arst_n, bus.dom_clk_en, bus.lock_lost, bus.timeout};
    endfunction

    task automatic tick(input logic raw, input logic en, input logic clr, input logic rst_n);
        @(negedge ref_clk);
        bus.pll_lock_raw  = raw;
        bus.dom_en        = en;
        bus.lock_lost_clr = clr;
        glb_rst_n         = rst_n;
        @(posedge ref_clk);
        model_step(raw, en, clr, rst_n);
        #1;
    endtask

    task automatic go_run(output bit ok);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            ok = (bus.state == 3'd2);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec() !== 8'h00) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b want %b", i, dut_vec(), 8'h00);
            end
        end
    endtask

    task automatic test_acquire();
        int n;
        bit seen;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL acquire_wait cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            n++;
            seen = bus.pll_lock;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL acquire cyc %0d: got %b want %b", n, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (!seen || n != SYNC + STABLE || bus.state !== 3'd2) begin
            miscompares++;
            $display("FAIL acquire_latency: got %0d cycles state %0d want %0d cycles state 2",
                     n, bus.state, SYNC + STABLE);
        end
    endtask

    task automatic test_glitch();
        int n;
        bit seen;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            n++;
            seen = (bus.state == 3'd2);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch cyc %0d: got %b want %b", n, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (!seen || n != SYNC + STABLE) begin
            miscompares++;
            $display("FAIL glitch_restart: got %0d cycles to RUN want %0d", n, SYNC + STABLE);
        end
    endtask

    task automatic test_lock_loss();
        int n_clk, n_rst;
        bit ok;
        go_run(ok);
        n_clk = 0;
        while (bus.dom_clk_en && n_clk < 20) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            n_clk++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL loss_gate cyc %0d: got %b want %b", n_clk, dut_vec(), exp_vec());
            end
        end
        n_rst = 0;
        while (bus.dom_arst_n && n_rst < 20) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            n_rst++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL loss_rst cyc %0d: got %b want %b", n_rst, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (!ok || n_clk < 2 || n_clk > 3 || n_rst != GATE || bus.lock_lost !== 1'b1 || bus.state !== 3'd1) begin
            miscompares++;
            $display("FAIL loss_seq: got clk %0d rst %0d lost %b state %0d want clk 2..3 rst %0d lost 1 state 1",
                     n_clk, n_rst, bus.lock_lost, bus.state, GATE);
        end
        go_run(ok);
        vectors++;
        if (!ok || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL loss_reacquire: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout();
        int n_acq;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_acq = 0;
        for (int i = 0; i < TMO + 20 && bus.state != 3'd4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.state == 3'd1) n_acq++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL timeout cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (n_acq != TMO || dut_vec() !== 8'b100_000_0_1) begin
            miscompares++;
            $display("FAIL timeout_fault: got %0d acq cycles vec %b want %0d vec %b", n_acq, dut_vec(), TMO, 8'b100_000_0_1);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (dut_vec() !== 8'b000_000_0_1) begin
            miscompares++;
            $display("FAIL timeout_off: got %b want %b", dut_vec(), 8'b000_000_0_1);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL timeout_clear: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_disable_gate();
        bit ok;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        go_run(ok);
        for (int i = 0; i < GATE + 2; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL disable cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (!ok || dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL disable_off: got %b want %b", dut_vec(), 8'h00);
        end
        go_run(ok);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (!ok || bus.lock_lost !== 1'b1 || bus.state !== 3'd3) begin
            miscompares++;
            $display("FAIL clr_vs_set: got lost %b state %0d want lost 1 state 3", bus.lock_lost, bus.state);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (dut_vec() !== exp_vec() || bus.lock_lost !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_alone: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        go_run(ok);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (!ok || dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_in_run: got %b want %b", dut_vec(), 8'h00);
        end
        go_run(ok);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (!ok || dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_in_gate: got %b want %b", dut_vec(), 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (dut_vec() !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_no_gate cyc %0d: got %b want %b", i, dut_vec(), 8'h00);
            end
        end
    endtask

    task automatic test_random();
        logic raw, en, clr, rst_n;
        int hold;
        raw = 0; en = 1; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                raw  = ($urandom_range(0, 3) != 0);
                hold = raw ? $urandom_range(1, 60) : $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) en = ~en;
            clr   = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick(raw, en, clr, rst_n);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.pll_lock_raw  = 1'b0;
        bus.dom_en        = 1'b0;
        bus.lock_lost_clr = 1'b0;
        test_reset();
        test_acquire();
        test_glitch();
        test_lock_loss();
        test_timeout();
        test_disable_gate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
